// File: rtl/bw_decoder.sv
// rtl/bw_decoder.sv - codeword-to-index reverse lookup over a writable table
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   tbl_we/addr/data      write one table entry and mark it valid
//   tbl_clr               invalidate every entry (a same-edge write still lands valid)
//   in_valid/ready/code   lookup request handshake
//   out_valid/ready       result handshake; result held until accepted
//   out_idx, out_hit      lowest matching index, or 0 with hit=0 on a miss
module bw_decoder #(
    parameter int CODE_W = 28,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tbl_we,
    input  logic [IDX_W-1:0]  tbl_addr,
    input  logic [CODE_W-1:0] tbl_data,
    input  logic              tbl_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_hit
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic              match;
    logic              last_entry;

    // Compare uses the table as it stood before this edge, so a write landing
    // on the same edge only affects later pointer positions.
    assign match      = ent_valid[ptr] && (mem[ptr] == code_q);
    assign last_entry = &ptr;
    assign in_ready   = (state == IDLE) && rst_n;

    // Codeword storage carries no reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            mem[tbl_addr] <= tbl_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
        end else begin
            if (tbl_clr) begin
                ent_valid <= '0;
            end
            // Placed after the clear so a simultaneous write wins for its entry.
            if (tbl_we) begin
                ent_valid[tbl_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            code_q    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_hit   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        code_q <= in_code;
                        ptr    <= '0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (match) begin
                        out_idx   <= ptr;
                        out_hit   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (last_entry) begin
                        out_idx   <= '0;
                        out_hit   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE takes this edge; acceptance waits for the next.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bw_decoder.sv
// tb/tb_bw_decoder.sv - directed self-checking bench for bw_decoder
module tb_bw_decoder;

    localparam int CODE_W = 28;
    localparam int IDX_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tbl_we = 1'b0;
    logic [IDX_W-1:0]  tbl_addr = '0;
    logic [CODE_W-1:0] tbl_data = '0;
    logic              tbl_clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CODE_W-1:0] in_code = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [IDX_W-1:0]  out_idx;
    logic              out_hit;

    int n_run  = 0;
    int n_fail = 0;

    bw_decoder #(.CODE_W(CODE_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .tbl_clr   (tbl_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_hit   (out_hit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [IDX_W-1:0] a, input logic [CODE_W-1:0] d);
        tbl_we   = 1'b1;
        tbl_addr = a;
        tbl_data = d;
        tick();
        tbl_we   = 1'b0;
    endtask

    task automatic accept(input logic [CODE_W-1:0] c);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        in_valid = 1'b1;
        in_code  = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_run++; if (out_idx !== 5'd0) begin n_fail++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
        n_run++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL reset_out_hit got=%b exp=0", out_hit); end
        rst_n = 1'b1;
        #1;
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_hit();
        int lat;
        write_entry(5'd7, 28'h0ABCDEF);
        out_ready = 1'b1;
        accept(28'h0ABCDEF);
        wait_done(0, lat);
        n_run++; if (lat !== 8) begin n_fail++; $display("FAIL hit7_latency got=%0d exp=8", lat); end
        n_run++; if (out_idx !== 5'd7) begin n_fail++; $display("FAIL hit7_idx got=%0d exp=7", out_idx); end
        n_run++; if (out_hit !== 1'b1) begin n_fail++; $display("FAIL hit7_hit got=%b exp=1", out_hit); end
        n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL done_in_ready got=%b exp=0", in_ready); end
        tick();
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_lowest();
        int lat;
        write_entry(5'd20, 28'h1234567);
        write_entry(5'd3, 28'h1234567);
        accept(28'h1234567);
        wait_done(0, lat);
        n_run++; if (lat !== 4) begin n_fail++; $display("FAIL lowest_latency got=%0d exp=4", lat); end
        n_run++; if (out_idx !== 5'd3) begin n_fail++; $display("FAIL lowest_idx got=%0d exp=3", out_idx); end
        n_run++; if (out_hit !== 1'b1) begin n_fail++; $display("FAIL lowest_hit got=%b exp=1", out_hit); end
        tick();
    endtask

    task automatic test_miss();
        int lat;
        accept(28'h0FFFFFF);
        wait_done(0, lat);
        n_run++; if (lat !== 32) begin n_fail++; $display("FAIL miss_latency got=%0d exp=32", lat); end
        n_run++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit got=%b exp=0", out_hit); end
        n_run++; if (out_idx !== 5'd0) begin n_fail++; $display("FAIL miss_idx got=%0d exp=0", out_idx); end
        tick();
        tbl_clr = 1'b1;
        tick();
        tbl_clr = 1'b0;
        accept(28'h0ABCDEF);
        wait_done(0, lat);
        n_run++; if (lat !== 32) begin n_fail++; $display("FAIL clr_latency got=%0d exp=32", lat); end
        n_run++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL clr_hit got=%b exp=0", out_hit); end
        tick();
    endtask

    task automatic test_clr_and_write();
        int lat;
        // Clear and write on the same edge: the written entry must survive.
        tbl_clr  = 1'b1;
        tbl_we   = 1'b1;
        tbl_addr = 5'd12;
        tbl_data = 28'h0C0FFEE;
        tick();
        tbl_clr  = 1'b0;
        tbl_we   = 1'b0;
        accept(28'h0C0FFEE);
        wait_done(0, lat);
        n_run++; if (lat !== 13) begin n_fail++; $display("FAIL clrwe_latency got=%0d exp=13", lat); end
        n_run++; if (out_idx !== 5'd12 || out_hit !== 1'b1) begin n_fail++; $display("FAIL clrwe_result got=%0d/%b exp=12/1", out_idx, out_hit); end
        tick();
    endtask

    task automatic test_stall();
        int lat;
        write_entry(5'd0, 28'h5555555);
        out_ready = 1'b0;
        accept(28'h5555555);
        wait_done(0, lat);
        n_run++; if (lat !== 1) begin n_fail++; $display("FAIL stall_latency got=%0d exp=1", lat); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_code  = 28'h0ABCDEF;
            tick();
            n_run++; if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_hit !== 1'b1) begin n_fail++; $display("FAIL stall_hold cyc=%0d got=%b/%0d/%b exp=1/0/1", i, out_valid, out_idx, out_hit); end
            n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        // in_valid held high throughout: DONE->IDLE edge must not accept.
        in_valid = 1'b1;
        in_code  = 28'h5555555;
        tick();
        n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got=%b exp=0", in_ready); end
        tick();
        n_run++; if (out_valid !== 1'b1 || out_idx !== 5'd0) begin n_fail++; $display("FAIL b2b_result got=%b/%0d exp=1/0", out_valid, out_idx); end
        tick();
        n_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b/%b exp=1/0", in_ready, out_valid); end
        tick();
        n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_reaccept got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        tick();
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second got=%b exp=1", out_valid); end
        tick();
    endtask

    task automatic test_reset_abort();
        int lat;
        write_entry(5'd15, 28'h0777777);
        accept(28'h0777777);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        n_run++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_now got=%b/%b exp=0/0", out_valid, in_ready); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_hold cyc=%0d got=%b exp=0", i, out_valid); end
        end
        rst_n = 1'b1;
        #1;
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%b exp=1", in_ready); end
        accept(28'h0777777);
        wait_done(0, lat);
        n_run++; if (lat !== 32) begin n_fail++; $display("FAIL abort_latency got=%0d exp=32", lat); end
        n_run++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL abort_hit got=%b exp=0", out_hit); end
        tick();
    endtask

    task automatic test_scan_write();
        int lat;
        accept(28'h0246813);
        repeat (5) tick();
        write_entry(5'd2, 28'h0246813);
        write_entry(5'd9, 28'h0246813);
        wait_done(7, lat);
        n_run++; if (lat !== 10) begin n_fail++; $display("FAIL scanwr_latency got=%0d exp=10", lat); end
        n_run++; if (out_idx !== 5'd9) begin n_fail++; $display("FAIL scanwr_idx got=%0d exp=9", out_idx); end
        n_run++; if (out_hit !== 1'b1) begin n_fail++; $display("FAIL scanwr_hit got=%b exp=1", out_hit); end
        tick();
    endtask

    initial begin
        test_reset();
        test_hit();
        test_lowest();
        test_miss();
        test_clr_and_write();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        test_scan_write();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
